vram_access_arbiter: RTL and testbench

//  Shares one single-port, 1-cycle-read video RAM between the display scan and game-logic writers.

---
 rtl/vram_access_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_access_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vram_access_arbiter                                          |
// | Description : Shares a single-port frame-buffer RAM between the display    |
// |               scan (priority while visible) and a 1-entry write buffer     |
// |               that drains only during blanking; also frame tick and stats. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vram_access_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int PIX_TOTAL = 307200
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              blank_n,
    input  logic              VS,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid,
    output logic              frame_start,
    output logic [15:0]       frame_writes
);

    localparam logic [ADDR_W-1:0] c_pix_last = ADDR_W'(PIX_TOTAL - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_vs_q;
    logic                r_frame_start;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [ADDR_W-1:0]   r_hold_addr;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_wr_drop;
    logic                r_pixel_valid;
    logic [15:0]         r_wr_count;
    logic [15:0]         r_frame_writes;

    logic                w_vs_fall;
    logic                w_oob;
    logic                w_accept;
    logic                w_commit;

    assign w_vs_fall = r_vs_q & ~VS;
    assign w_oob     = (wr_addr > c_pix_last);
    assign w_accept  = wr_valid & wr_ready;

    always_comb begin
        w_next_state = r_state;
        wr_ready     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid && !w_oob) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                // Blanking cycle: drain the buffer and refill it in the same cycle
                if (!blank_n) begin
                    wr_ready     = 1'b1;
                    w_commit     = 1'b1;
                    w_next_state = (wr_valid && !w_oob) ? S_HOLD : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign ram_we       = w_commit;
    assign ram_addr     = blank_n ? r_disp_addr : r_hold_addr;
    assign ram_wdata    = r_hold_data;
    assign pixel_valid  = r_pixel_valid;
    assign pixel_data   = r_pixel_valid ? ram_rdata : '0;
    assign wr_drop      = r_wr_drop;
    assign frame_start  = r_frame_start;
    assign frame_writes = r_frame_writes;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_vs_q         <= 1'b1;
            r_frame_start  <= 1'b0;
            r_disp_addr    <= '0;
            r_hold_addr    <= '0;
            r_hold_data    <= '0;
            r_wr_drop      <= 1'b0;
            r_pixel_valid  <= 1'b0;
            r_wr_count     <= '0;
            r_frame_writes <= '0;
        end else begin
            r_state       <= w_next_state;
            r_vs_q        <= VS;
            r_frame_start <= w_vs_fall;
            r_pixel_valid <= blank_n;
            r_wr_drop     <= w_accept & w_oob;

            if (w_accept) begin
                r_hold_addr <= wr_addr;
                r_hold_data <= wr_data;
            end

            if (w_vs_fall) begin
                r_disp_addr <= '0;
            end else if (blank_n) begin
                r_disp_addr <= (r_disp_addr == c_pix_last) ? '0 : r_disp_addr + 1'b1;
            end

            // A commit landing on the frame boundary belongs to the new frame
            if (w_vs_fall) begin
                r_frame_writes <= r_wr_count;
                r_wr_count     <= w_commit ? 16'd1 : 16'd0;
            end else if (w_commit && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vram_access_arbiter                                       |
// | Description : Directed self-checking bench for vram_access_arbiter with a  |
// |               small 1-cycle-read RAM model on the memory port.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vram_access_arbiter;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int PIX_TOTAL = 307200;

    logic              vga_clk = 1'b0;
    logic              reset;
    logic              blank_n;
    logic              VS;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_drop;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] pixel_data;
    logic              pixel_valid;
    logic              frame_start;
    logic [15:0]       frame_writes;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] mem [0:1023];

    always #5 vga_clk = ~vga_clk;

    vram_access_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .PIX_TOTAL (PIX_TOTAL)
    ) dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .blank_n      (blank_n),
        .VS           (VS),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_drop      (wr_drop),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .frame_writes (frame_writes)
    );

    // RAM model: low 10 address bits, known fill pattern while reset is high
    always @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'((i * 7 + 3) & 255);
        end else if (ram_we) begin
            mem[ram_addr[9:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[9:0]];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    int bad_ready, bad_we, bad_addr, bad_pix, fs_cnt;

    initial begin
        reset = 1'b1; blank_n = 1'b1; VS = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset in the middle of a held write
        wr_valid = 1'b1; wr_addr = 19'd7; wr_data = 8'h11;
        #1 check_val("idle_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        #1 check_val("hold_ready_visible", 32'(wr_ready), 32'd0);
        reset = 1'b1;
        bad_we = 0;
        for (int i = 0; i < 3; i++) begin
            #1 if (ram_we !== 1'b0) bad_we++;
            tick();
        end
        check_val("rst_no_we", 32'(bad_we), 32'd0);
        reset = 1'b0;
        #1;
        check_val("rst_ready", 32'(wr_ready), 32'd1);
        check_val("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_val("rst_wr_drop", 32'(wr_drop), 32'd0);
        check_val("rst_frame_start", 32'(frame_start), 32'd0);
        check_val("rst_frame_writes", 32'(frame_writes), 32'd0);
        check_val("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check_val("rst_pixel_data", 32'(pixel_data), 32'd0);
        blank_n = 1'b0;
        #1 check_val("rst_buffer_lost", 32'(ram_we), 32'd0);
        tick();

        // Blanking write commits the next cycle
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 8'hA5;
        #1 check_val("w5_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        #1;
        check_val("w5_we", 32'(ram_we), 32'd1);
        check_val("w5_addr", 32'(ram_addr), 32'd5);
        check_val("w5_data", 32'(ram_wdata), 32'hA5);
        check_val("w5_ready_commit", 32'(wr_ready), 32'd1);
        tick();

        // Write held through 10 visible cycles
        blank_n = 1'b1; wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 8'h3C;
        tick();
        wr_valid = 1'b0;
        bad_ready = 0; bad_we = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wr_ready !== 1'b0) bad_ready++;
            if (ram_we !== 1'b0) bad_we++;
            tick();
        end
        check_val("w100_ready_low", 32'(bad_ready), 32'd0);
        check_val("w100_no_we", 32'(bad_we), 32'd0);
        blank_n = 1'b0;
        #1;
        check_val("w100_we", 32'(ram_we), 32'd1);
        check_val("w100_addr", 32'(ram_addr), 32'd100);
        check_val("w100_data", 32'(ram_wdata), 32'h3C);
        tick();

        // Out-of-range write dropped, last legal address accepted
        wr_valid = 1'b1; wr_addr = 19'(PIX_TOTAL); wr_data = 8'hEE;
        tick();
        wr_valid = 1'b0;
        #1;
        check_val("oob_drop", 32'(wr_drop), 32'd1);
        check_val("oob_no_we", 32'(ram_we), 32'd0);
        check_val("oob_ready", 32'(wr_ready), 32'd1);
        tick();
        check_val("oob_drop_pulse", 32'(wr_drop), 32'd0);
        wr_valid = 1'b1; wr_addr = 19'(PIX_TOTAL - 1); wr_data = 8'h77;
        tick();
        wr_valid = 1'b0;
        #1;
        check_val("last_we", 32'(ram_we), 32'd1);
        check_val("last_addr", 32'(ram_addr), 32'(PIX_TOTAL - 1));
        check_val("last_no_drop", 32'(wr_drop), 32'd0);
        tick();

        // Back-to-back writes at full rate
        wr_valid = 1'b1; wr_addr = 19'd10; wr_data = 8'h01;
        tick();
        wr_addr = 19'd11; wr_data = 8'h02;
        #1;
        check_val("b2b_ready", 32'(wr_ready), 32'd1);
        check_val("b2b_addr0", 32'(ram_addr), 32'd10);
        tick();
        wr_valid = 1'b0;
        #1;
        check_val("b2b_we1", 32'(ram_we), 32'd1);
        check_val("b2b_addr1", 32'(ram_addr), 32'd11);
        check_val("b2b_data1", 32'(ram_wdata), 32'h02);
        tick();

        // Commit on the VS falling-edge cycle: 5 commits so far, new frame starts at 1
        wr_valid = 1'b1; wr_addr = 19'd20; wr_data = 8'h09;
        tick();
        wr_valid = 1'b0; VS = 1'b0;
        #1 check_val("vsf_commit", 32'(ram_we), 32'd1);
        tick();
        check_val("vsf_frame_start", 32'(frame_start), 32'd1);
        check_val("vsf_frame_writes", 32'(frame_writes), 32'd5);
        VS = 1'b1;
        tick();
        check_val("vsf_pulse_once", 32'(frame_start), 32'd0);
        VS = 1'b0;
        tick();
        check_val("next_frame_writes", 32'(frame_writes), 32'd1);

        // 640 visible pixels scanned from address 0
        blank_n = 1'b1;
        bad_addr = 0; bad_pix = 0; fs_cnt = 0;
        for (int i = 0; i < 640; i++) begin
            #1;
            if (frame_start === 1'b1) fs_cnt++;
            if (ram_addr !== 19'(i)) bad_addr++;
            if (i == 0) begin
                if (pixel_valid !== 1'b0 || pixel_data !== 8'h00) bad_pix++;
            end else begin
                if (pixel_valid !== 1'b1 || pixel_data !== mem[i - 1]) bad_pix++;
            end
            tick();
        end
        check_val("scan_frame_start_cnt", 32'(fs_cnt), 32'd1);
        check_val("scan_addr_errs", 32'(bad_addr), 32'd0);
        check_val("scan_pixel_errs", 32'(bad_pix), 32'd0);
        check_val("scan_pix5", 32'(mem[5]), 32'hA5);
        blank_n = 1'b0;
        #1;
        check_val("scan_last_valid", 32'(pixel_valid), 32'd1);
        check_val("scan_last_pixel", 32'(pixel_data), 32'(mem[639]));
        tick();
        check_val("blank_pixel_valid", 32'(pixel_valid), 32'd0);
        check_val("blank_pixel_data", 32'(pixel_data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
